// File: rtl/mem_pkg.sv
// Shared data-memory definitions: access-size encodings (funct3) and the responder FSM states.
// Imported by the memory/writeback stage as well as the responder.
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } memop_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for a 32-bit little-endian data port: store byte-enables and
// replicated write data, alignment/illegal-op detection, and load byte/half extraction with extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic        isWrite,
    input  logic [2:0]  op,
    input  logic [1:0]  addrLo,
    input  logic [31:0] wdata,
    input  logic [31:0] rawWord,
    output logic [3:0]  byteEn,
    output logic [31:0] wdataShifted,
    output logic        accessErr,
    output logic [31:0] loadData
);

    logic        illegal;
    logic        misaligned;
    logic [3:0]  laneMask;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        illegal      = 1'b0;
        misaligned   = 1'b0;
        laneMask     = 4'b0000;
        wdataShifted = 32'h0;
        case (op)
            F3_B, F3_BU: begin
                laneMask     = 4'b0001 << addrLo;
                wdataShifted = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                misaligned   = addrLo[0];
                laneMask     = addrLo[1] ? 4'b1100 : 4'b0011;
                wdataShifted = {2{wdata[15:0]}};
            end
            F3_W: begin
                misaligned   = |addrLo;
                laneMask     = 4'b1111;
                wdataShifted = wdata;
            end
            default: illegal = 1'b1;
        endcase
        // Unsigned variants only make sense for loads.
        if (isWrite && (op == F3_BU || op == F3_HU)) begin
            illegal = 1'b1;
        end
        accessErr = illegal | misaligned;
        byteEn    = (isWrite && !accessErr) ? laneMask : 4'b0000;
    end

    always_comb begin
        byteSel  = 8'(rawWord >> {addrLo, 3'b000});
        halfSel  = addrLo[1] ? rawWord[31:16] : rawWord[15:0];
        loadData = 32'h0;
        case (op)
            F3_B:    loadData = {{24{byteSel[7]}}, byteSel};
            F3_BU:   loadData = {24'h0, byteSel};
            F3_H:    loadData = {{16{halfSel[15]}}, halfSel};
            F3_HU:   loadData = {16'h0, halfSel};
            F3_W:    loadData = rawWord;
            default: loadData = 32'h0;
        endcase
        if (accessErr) begin
            loadData = 32'h0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one request at a time, store committed on acceptance,
// load sampled from four byte-wide banks on the edge entering RESP.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int         WORD_BITS = ADDR_WIDTH - 2;
    localparam int         DEPTH     = 2 ** WORD_BITS;
    localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);

    resp_state_t           stateReg, stateNext;
    logic [3:0]            cntReg, cntNext;
    logic                  writeReg;
    logic [2:0]            opReg;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic                  errReg;

    logic                  accept;
    logic                  loadSample;
    logic                  alignSel;
    logic                  alignWrite;
    logic [2:0]            alignOp;
    logic [1:0]            alignAddrLo;
    logic [3:0]            byteEn;
    logic [31:0]           wdataShifted;
    logic                  accessErr;
    logic [31:0]           rawWord;
    logic [31:0]           loadData;
    logic [WORD_BITS-1:0]  reqWord;
    logic [WORD_BITS-1:0]  readWord;
    logic                  unusedAddrBits;

    assign unusedAddrBits = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];

    assign req_ready = rst_n && (stateReg == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    stateNext = (LATENCY > 1) ? WAIT : RESP;
                    cntNext   = CNT_LOAD;
                end
            end
            WAIT: begin
                cntNext = cntReg - 4'd1;
                if (cntReg == 4'd1) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg <= IDLE;
            cntReg   <= 4'd0;
            writeReg <= 1'b0;
            opReg    <= 3'b000;
            addrReg  <= '0;
            errReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            if (accept) begin
                writeReg <= req_write;
                opReg    <= req_op;
                addrReg  <= req_addr[ADDR_WIDTH-1:0];
                errReg   <= accessErr;
            end
        end
    end

    // In IDLE the aligner sees the live request (store commit, error check);
    // afterwards it sees the latched request for load extraction.
    assign alignSel    = (stateReg == IDLE);
    assign alignWrite  = alignSel ? req_write : writeReg;
    assign alignOp     = alignSel ? req_op : opReg;
    assign alignAddrLo = alignSel ? req_addr[1:0] : addrReg[1:0];

    mem_lane_align u_align (
        .isWrite      (alignWrite),
        .op           (alignOp),
        .addrLo       (alignAddrLo),
        .wdata        (req_wdata),
        .rawWord      (rawWord),
        .byteEn       (byteEn),
        .wdataShifted (wdataShifted),
        .accessErr    (accessErr),
        .loadData     (loadData)
    );

    // With LATENCY=1 the RESP-entry edge is the acceptance edge, so read from the live address.
    assign loadSample = rst_n && (stateReg != RESP) && (stateNext == RESP);
    assign reqWord    = req_addr[ADDR_WIDTH-1:2];
    assign readWord   = alignSel ? reqWord : addrReg[ADDR_WIDTH-1:2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gBank
            logic [7:0] bank [DEPTH];
            logic [7:0] rawByte;

            always_ff @(posedge clk) begin
                if (accept && byteEn[gi]) begin
                    bank[reqWord] <= wdataShifted[8*gi +: 8];
                end
                if (loadSample) begin
                    rawByte <= bank[readWord];
                end
            end

            assign rawWord[8*gi +: 8] = rawByte;
        end
    endgenerate

    assign resp_valid = (stateReg == RESP);
    assign resp_err   = resp_valid && errReg;
    assign resp_rdata = (resp_valid && !writeReg) ? loadData : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a LATENCY=2 instance plus stall, reset and
// back-to-back LATENCY=1 sequences.
module tb_dmem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic        rst_n;
    logic        reqValid, reqReady, reqWrite;
    logic [2:0]  reqOp;
    logic [31:0] reqAddr, reqWdata;
    logic        respValid, respReady, respErr;
    logic [31:0] respRdata;

    logic        l1ReqValid, l1ReqReady, l1ReqWrite;
    logic [2:0]  l1ReqOp;
    logic [31:0] l1ReqAddr, l1ReqWdata;
    logic        l1RespValid, l1RespReady, l1RespErr;
    logic [31:0] l1RespRdata;

    int compared   = 0;
    int mismatched = 0;

    dmem_responder #(.LATENCY(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (reqValid),
        .req_ready  (reqReady),
        .req_write  (reqWrite),
        .req_op     (reqOp),
        .req_addr   (reqAddr),
        .req_wdata  (reqWdata),
        .resp_valid (respValid),
        .resp_ready (respReady),
        .resp_rdata (respRdata),
        .resp_err   (respErr)
    );

    dmem_responder #(.LATENCY(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (l1ReqValid),
        .req_ready  (l1ReqReady),
        .req_write  (l1ReqWrite),
        .req_op     (l1ReqOp),
        .req_addr   (l1ReqAddr),
        .req_wdata  (l1ReqWdata),
        .resp_valid (l1RespValid),
        .resp_ready (l1RespReady),
        .resp_rdata (l1RespRdata),
        .resp_err   (l1RespErr)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] expRdata, input logic expErr);
        vec_t v;
        v.wr = wr; v.op = op; v.addr = addr; v.wdata = wdata;
        v.expRdata = expRdata; v.expErr = expErr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present a request on the LATENCY=2 port; returns just after its acceptance edge.
    task automatic issue(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        while (!reqReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_issue", {31'h0, reqReady}, 32'h1);
        reqValid = 1'b1; reqWrite = wr; reqOp = op; reqAddr = addr; reqWdata = wdata;
        @(posedge clk);
        #1 reqValid = 1'b0;
    endtask

    // Counts falling edges after acceptance until resp_valid is seen.
    task automatic waitResp(output int lat);
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            lat++;
            if (respValid) break;
        end
        check("resp_valid_timeout", {31'h0, respValid}, 32'h1);
    endtask

    task automatic finishResp();
        respReady = 1'b1;
        @(posedge clk);
        #1 respReady = 1'b0;
    endtask

    task automatic runVec(input int idx, input vec_t v);
        int lat;
        issue(v.wr, v.op, v.addr, v.wdata);
        waitResp(lat);
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'd2);
        check($sformatf("v%0d_rdata", idx), respRdata, v.expRdata);
        check($sformatf("v%0d_err", idx), {31'h0, respErr}, {31'h0, v.expErr});
        $display("txn v%0d wr=%0b op=%03b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
                 idx, v.wr, v.op, v.addr, v.wdata, respRdata, respErr, lat);
        finishResp();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int accCycle, prevAcc;
        vec_t l1[$];
        vec_t v;

        rst_n = 1'b0;
        reqValid = 1'b0; reqWrite = 1'b0; reqOp = 3'b000; reqAddr = '0; reqWdata = '0;
        respReady = 1'b0;
        l1ReqValid = 1'b0; l1ReqWrite = 1'b0; l1ReqOp = 3'b000; l1ReqAddr = '0; l1ReqWdata = '0;
        l1RespReady = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'h0, reqReady}, 32'h0);
        check("rst_resp_valid", {31'h0, respValid}, 32'h0);
        check("rst_resp_rdata", respRdata, 32'h0);
        check("rst_resp_err", {31'h0, respErr}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", {31'h0, reqReady}, 32'h1);
        $display("txn reset released req_ready=%0b", reqReady);

        addVec(1'b1, F3_W,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0);
        addVec(1'b0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0);
        addVec(1'b0, F3_B,  32'h103, 32'h0,        32'hFFFFFFDE, 1'b0);
        addVec(1'b0, F3_BU, 32'h103, 32'h0,        32'h000000DE, 1'b0);
        addVec(1'b0, F3_H,  32'h100, 32'h0,        32'hFFFFBEEF, 1'b0);
        addVec(1'b0, F3_HU, 32'h102, 32'h0,        32'h0000DEAD, 1'b0);
        addVec(1'b1, F3_H,  32'h101, 32'h1234,     32'h0,        1'b1);
        addVec(1'b0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0);
        addVec(1'b0, F3_W,  32'h102, 32'h0,        32'h0,        1'b1);
        addVec(1'b1, F3_BU, 32'h100, 32'h77,       32'h0,        1'b1);
        addVec(1'b0, 3'b011, 32'h100, 32'h0,       32'h0,        1'b1);
        addVec(1'b0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0);
        addVec(1'b1, F3_B,  32'h200, 32'hFFFFFF5A, 32'h0,        1'b0);
        addVec(1'b0, F3_BU, 32'h200, 32'h0,        32'h0000005A, 1'b0);
        addVec(1'b1, F3_W,  32'h204, 32'h11223344, 32'h0,        1'b0);
        addVec(1'b1, F3_B,  32'h205, 32'h000000AB, 32'h0,        1'b0);
        addVec(1'b0, F3_W,  32'h204, 32'h0,        32'h1122AB44, 1'b0);
        addVec(1'b1, F3_H,  32'h206, 32'h0000CAFE, 32'h0,        1'b0);
        addVec(1'b0, F3_W,  32'h204, 32'h0,        32'hCAFEAB44, 1'b0);
        addVec(1'b0, F3_H,  32'h206, 32'h0,        32'hFFFFCAFE, 1'b0);
        addVec(1'b0, F3_B,  32'h204, 32'h0,        32'h00000044, 1'b0);
        addVec(1'b0, F3_B,  32'h205, 32'h0,        32'hFFFFFFAB, 1'b0);

        foreach (vecs[i]) runVec(i, vecs[i]);

        // resp_ready withheld: response and req_ready must hold for 5 cycles
        issue(1'b0, F3_W, 32'h100, 32'h0);
        waitResp(lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_resp_valid", {31'h0, respValid}, 32'h1);
            check("stall_rdata", respRdata, 32'hDEADBEEF);
            check("stall_err", {31'h0, respErr}, 32'h0);
            check("stall_req_ready", {31'h0, reqReady}, 32'h0);
        end
        finishResp();
        @(negedge clk);
        check("stall_release_req_ready", {31'h0, reqReady}, 32'h1);
        check("stall_release_resp_valid", {31'h0, respValid}, 32'h0);
        $display("txn stall LW 0x100 held 5 cycles, released req_ready=%0b", reqReady);

        // Reset pulsed while a load is in WAIT: response discarded, memory kept
        issue(1'b0, F3_W, 32'h100, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        check("midrst_req_ready", {31'h0, reqReady}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_resp", {31'h0, respValid}, 32'h0);
        end
        check("midrst_idle_ready", {31'h0, reqReady}, 32'h1);
        $display("txn reset during WAIT, resp_valid=%0b req_ready=%0b", respValid, reqReady);
        v.wr = 1'b0; v.op = F3_BU; v.addr = 32'h200; v.wdata = 32'h0;
        v.expRdata = 32'h0000005A; v.expErr = 1'b0;
        runVec(100, v);

        // LATENCY=1 instance, resp_ready tied high, request held valid back to back
        v.wr = 1'b1; v.op = F3_W;  v.addr = 32'h40; v.wdata = 32'hA5A50F0F; v.expRdata = 32'h0;        v.expErr = 1'b0; l1.push_back(v);
        v.wr = 1'b0; v.op = F3_W;  v.addr = 32'h40; v.wdata = 32'h0;        v.expRdata = 32'hA5A50F0F; l1.push_back(v);
        v.wr = 1'b0; v.op = F3_HU; v.addr = 32'h42; v.expRdata = 32'h0000A5A5; l1.push_back(v);
        v.wr = 1'b0; v.op = F3_B;  v.addr = 32'h40; v.expRdata = 32'h0000000F; l1.push_back(v);
        v.wr = 1'b0; v.op = F3_H;  v.addr = 32'h40; v.expRdata = 32'h00000F0F; l1.push_back(v);
        v.wr = 1'b0; v.op = F3_B;  v.addr = 32'h43; v.expRdata = 32'hFFFFFFA5; l1.push_back(v);

        prevAcc = 0;
        @(negedge clk);
        foreach (l1[i]) begin
            int n = 0;
            while (!l1ReqReady && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("l1_req_ready", {31'h0, l1ReqReady}, 32'h1);
            l1ReqValid = 1'b1; l1ReqWrite = l1[i].wr; l1ReqOp = l1[i].op;
            l1ReqAddr = l1[i].addr; l1ReqWdata = l1[i].wdata;
            @(posedge clk);
            #1 accCycle = cycle;
            @(negedge clk);
            check($sformatf("l1_%0d_resp_valid", i), {31'h0, l1RespValid}, 32'h1);
            check($sformatf("l1_%0d_rdata", i), l1RespRdata, l1[i].expRdata);
            check($sformatf("l1_%0d_err", i), {31'h0, l1RespErr}, {31'h0, l1[i].expErr});
            if (i > 0) check($sformatf("l1_%0d_spacing", i), 32'(accCycle - prevAcc), 32'd2);
            $display("txn l1_%0d wr=%0b op=%03b addr=%h -> rdata=%h err=%0b spacing=%0d",
                     i, l1[i].wr, l1[i].op, l1[i].addr, l1RespRdata, l1RespErr, accCycle - prevAcc);
            prevAcc = accCycle;
        end
        l1ReqValid = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
